mac_accum_pipe: RTL

Pipelined, parametrised multiply-accumulate engine that succeeds the fixed-width unsigned accumulator. It adds per-sample signed/unsigned mode, framed accumulation with explicit first/last markers, a configurable multiplier pipeline, a wider accumulator with saturate-or-wrap overflow handling, and a result-valid strobe. It sits in the arithmetic datapath between sample sources (filters, correlators) and result consumers.

---
 rtl/mac_pkg.sv | 44 ++++
 rtl/mac_mult_pipe.sv | 84 ++++++++
 rtl/mac_accum_pipe.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and constant helpers for the pipelined multiply-accumulate engine.
package mac_pkg;

    typedef enum logic {
        MAC_UNSIGNED = 1'b0,
        MAC_SIGNED   = 1'b1
    } mac_mode_e;

    // Control that travels alongside each product through the multiplier pipeline.
    typedef struct packed {
        logic      valid;
        logic      first;
        logic      last;
        mac_mode_e mode;
        logic      satEn;
    } mac_side_t;

    localparam int MAC_LIMIT_WIDTH = 128;
    typedef logic [MAC_LIMIT_WIDTH-1:0] mac_limit_t;

    function automatic int mac_latency(input int mulStages);
        return mulStages + 1;
    endfunction

    function automatic mac_limit_t mac_sat_max(input int width, input mac_mode_e mode);
        mac_limit_t one;
        one = mac_limit_t'(1);
        if (mode == MAC_SIGNED) begin
            return (one << (width - 1)) - one;
        end
        return (one << width) - one;
    endfunction

    // Signed minimum is the all-ones pattern shifted up; truncation leaves 100..0.
    function automatic mac_limit_t mac_sat_min(input int width, input mac_mode_e mode);
        mac_limit_t allOnes;
        allOnes = ~mac_limit_t'(0);
        if (mode == MAC_SIGNED) begin
            return allOnes << (width - 1);
        end
        return '0;
    endfunction

endpackage

// File: rtl/mac_mult_pipe.sv
// Input register followed by MUL_STAGES product registers, with a sideband of
// per-sample control carried in lockstep with the product.
module mac_mult_pipe
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MUL_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    aclr,
    input  logic                    clken_i,
    input  logic                    valid_i,
    input  logic                    first_i,
    input  logic                    last_i,
    input  mac_mode_e               mode_i,
    input  logic                    satEn_i,
    input  logic [DATA_WIDTH-1:0]   dataA_i,
    input  logic [DATA_WIDTH-1:0]   dataB_i,
    output logic [2*DATA_WIDTH-1:0] prod_o,
    output mac_side_t               side_o
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] opA_q;
    logic [DATA_WIDTH-1:0] opB_q;
    mac_side_t             side_q;
    mac_side_t             side_d;

    logic signed [PW-1:0]  prodSigned;
    logic        [PW-1:0]  prodUnsigned;
    logic        [PW-1:0]  prod_d;

    logic [PW-1:0] prod_q  [MUL_STAGES];
    mac_side_t     pside_q [MUL_STAGES];

    always_comb begin
        side_d.valid = valid_i;
        side_d.first = first_i;
        side_d.last  = last_i;
        side_d.mode  = mode_i;
        side_d.satEn = satEn_i;
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            opA_q  <= '0;
            opB_q  <= '0;
            side_q <= '0;
        end else if (clken_i) begin
            opA_q  <= dataA_i;
            opB_q  <= dataB_i;
            side_q <= side_d;
        end
    end

    // Operands are widened to the full product width first so the low PW bits
    // of the multiply are exact in either mode.
    always_comb begin
        prodSigned   = PW'($signed(opA_q)) * PW'($signed(opB_q));
        prodUnsigned = PW'(opA_q) * PW'(opB_q);
        prod_d       = (side_q.mode == MAC_SIGNED) ? prodSigned : prodUnsigned;
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                prod_q[i]  <= '0;
                pside_q[i] <= '0;
            end
        end else if (clken_i) begin
            prod_q[0]  <= prod_d;
            pside_q[0] <= side_q;
            for (int i = 1; i < MUL_STAGES; i++) begin
                prod_q[i]  <= prod_q[i-1];
                pside_q[i] <= pside_q[i-1];
            end
        end
    end

    assign prod_o = prod_q[MUL_STAGES-1];
    assign side_o = pside_q[MUL_STAGES-1];

endmodule

// File: rtl/mac_accum_pipe.sv
// Pipelined multiply-accumulate engine: framed accumulation with per-sample
// signed/unsigned mode, saturate-or-wrap overflow handling and a result strobe.
module mac_accum_pipe
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int MUL_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  aclr,
    input  logic                  clken,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic                  signed_mode,
    input  logic                  sat_en,
    input  logic [DATA_WIDTH-1:0] dataa,
    input  logic [DATA_WIDTH-1:0] datab,
    output logic [ACC_WIDTH-1:0]  acc_out,
    output logic                  out_valid,
    output logic                  overflow
);

    if (DATA_WIDTH < 2 || DATA_WIDTH > 32) begin : g_bad_data_width
        $error("mac_accum_pipe: DATA_WIDTH must be in 2..32");
    end
    if (ACC_WIDTH < 2 * DATA_WIDTH || ACC_WIDTH >= MAC_LIMIT_WIDTH) begin : g_bad_acc_width
        $error("mac_accum_pipe: ACC_WIDTH must be at least 2*DATA_WIDTH");
    end
    if (MUL_STAGES < 1 || MUL_STAGES > 4) begin : g_bad_mul_stages
        $error("mac_accum_pipe: MUL_STAGES must be in 1..4");
    end

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [ACC_WIDTH-1:0] SAT_MAX_U = ACC_WIDTH'(mac_sat_max(ACC_WIDTH, MAC_UNSIGNED));
    localparam logic [ACC_WIDTH-1:0] SAT_MAX_S = ACC_WIDTH'(mac_sat_max(ACC_WIDTH, MAC_SIGNED));
    localparam logic [ACC_WIDTH-1:0] SAT_MIN_S = ACC_WIDTH'(mac_sat_min(ACC_WIDTH, MAC_SIGNED));

    logic [PW-1:0]        prod;
    mac_side_t            side;

    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic                 overflow_q;
    logic                 overflow_d;
    logic                 outValid_q;
    logic                 outValid_d;

    logic [ACC_WIDTH-1:0] prodExt;
    logic [ACC_WIDTH:0]   sumFull;
    logic [ACC_WIDTH-1:0] sum;
    logic                 sumOvf;
    logic [ACC_WIDTH-1:0] satValue;

    mac_mult_pipe #(
        .DATA_WIDTH(DATA_WIDTH),
        .MUL_STAGES(MUL_STAGES)
    ) u_mult (
        .clk     (clk),
        .aclr    (aclr),
        .clken_i (clken),
        .valid_i (in_valid),
        .first_i (in_first),
        .last_i  (in_last),
        .mode_i  (mac_mode_e'(signed_mode)),
        .satEn_i (sat_en),
        .dataA_i (dataa),
        .dataB_i (datab),
        .prod_o  (prod),
        .side_o  (side)
    );

    // Signed overflow: both addends share a sign that the sum does not; the
    // addend sign then gives the clamp direction.
    always_comb begin
        if (side.mode == MAC_SIGNED) begin
            prodExt = ACC_WIDTH'($signed(prod));
        end else begin
            prodExt = ACC_WIDTH'(prod);
        end

        sumFull = {1'b0, acc_q} + {1'b0, prodExt};
        sum     = sumFull[ACC_WIDTH-1:0];

        if (side.mode == MAC_SIGNED) begin
            sumOvf   = (acc_q[ACC_WIDTH-1] == prodExt[ACC_WIDTH-1]) &&
                       (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
            satValue = prodExt[ACC_WIDTH-1] ? SAT_MIN_S : SAT_MAX_S;
        end else begin
            sumOvf   = sumFull[ACC_WIDTH];
            satValue = SAT_MAX_U;
        end
    end

    always_comb begin
        acc_d      = acc_q;
        overflow_d = overflow_q;
        outValid_d = 1'b0;
        if (side.valid) begin
            outValid_d = side.last;
            if (side.first) begin
                acc_d      = prodExt;
                overflow_d = 1'b0;
            end else if (sumOvf) begin
                overflow_d = 1'b1;
                acc_d      = side.satEn ? satValue : sum;
            end else begin
                acc_d      = sum;
            end
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            acc_q      <= '0;
            overflow_q <= 1'b0;
            outValid_q <= 1'b0;
        end else if (clken) begin
            acc_q      <= acc_d;
            overflow_q <= overflow_d;
            outValid_q <= outValid_d;
        end
    end

    assign acc_out   = acc_q;
    assign overflow  = overflow_q;
    assign out_valid = outValid_q;

endmodule
